// File: rtl/geofence_pkg.sv
// Shared widths, point record and FSM encoding for the geofence test driver.
// The driver streams six anchor points to a geofence block and scores its answer.
package geofence_pkg;

  localparam int COORD_W    = 10;
  localparam int RADIUS_W   = 11;
  localparam int AREA_W     = 22;
  localparam int NUM_POINTS = 6;
  localparam int IDX_W      = 3;

  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [RADIUS_W-1:0] r;
  } point_t;

  localparam int POINT_W = $bits(point_t);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_CHECK
  } state_t;

  function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
    return idx <= LAST_IDX;
  endfunction

endpackage

// File: rtl/gf_point_buf.sv
// Six-entry anchor point register file: one write port, one asynchronous read port.
// Out-of-range indices (6, 7) are dropped on write and read back as zero.
module gf_point_buf
  import geofence_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  point_t           wr_point,
  input  logic [IDX_W-1:0] rd_idx,
  output point_t           rd_point
);

  point_t mem [NUM_POINTS];

  // NOTE: the slots are flops, not RAM, so clearing them on reset is cheap and
  // guarantees a reset driver streams zeros rather than stale anchors.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_POINTS; i++) mem[i] <= '0;
    end else if (wr_en && idx_valid(wr_idx)) begin
      mem[wr_idx] <= wr_point;
    end
  end

  always_comb begin
    rd_point = '0;
    if (idx_valid(rd_idx)) rd_point = mem[rd_idx];
  end

endmodule

// File: rtl/geofence_driver.sv
// Geofence driver: streams the buffered anchors, waits for the geofence verdict,
// compares it with the latched golden answer and keeps pass/fail statistics.
module geofence_driver
  import geofence_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [COORD_W-1:0]  wr_x,
  input  logic [COORD_W-1:0]  wr_y,
  input  logic [RADIUS_W-1:0] wr_r,
  input  logic                gold_in,
  input  logic [AREA_W-1:0]   gold_area,
  input  logic                start,
  output logic [COORD_W-1:0]  X,
  output logic [COORD_W-1:0]  Y,
  output logic [RADIUS_W-1:0] R,
  input  logic                gf_valid,
  input  logic                gf_inside,
  input  logic [AREA_W-1:0]   gf_area,
  output logic                busy,
  output logic                done,
  output logic                last_pass,
  output logic                timeout_flag,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt
);

  localparam int               WAIT_W     = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0]  SEND_END   = IDX_W'(NUM_POINTS);

  state_t              state, state_n;
  logic [IDX_W-1:0]    send_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_hit;
  logic                result_pass;
  logic                gold_inside_q;
  logic [AREA_W-1:0]   gold_area_q;
  logic                cap_inside;
  logic [AREA_W-1:0]   cap_area;
  point_t              out_q;
  point_t              rd_point;
  point_t              wr_point;

  assign wr_point = '{x: wr_x, y: wr_y, r: wr_r};

  // send_cnt runs one slot ahead of the point on X/Y/R so the output register
  // can be loaded from the read port; it sits at 0 throughout IDLE.
  gf_point_buf u_point_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en && (state == ST_IDLE)),
    .wr_idx   (wr_idx),
    .wr_point (wr_point),
    .rd_idx   (send_cnt),
    .rd_point (rd_point)
  );

  assign wait_hit    = (state == ST_WAIT) && (wait_cnt == WAIT_LIMIT);
  assign result_pass = (cap_inside == gold_inside_q) && (cap_area == gold_area_q);

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_n = state;
    busy    = (state != ST_IDLE);
    done    = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_n = ST_SEND;
      ST_SEND:  if (send_cnt == SEND_END) state_n = ST_WAIT;
      ST_WAIT: begin
        if (wait_hit) begin
          state_n = ST_IDLE;
          done    = 1'b1;
        end else if (gf_valid) begin
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_n = ST_IDLE;
        done    = 1'b1;
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      send_cnt      <= '0;
      wait_cnt      <= '0;
      out_q         <= '0;
      gold_inside_q <= 1'b0;
      gold_area_q   <= '0;
      cap_inside    <= 1'b0;
      cap_area      <= '0;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      last_pass     <= 1'b0;
      timeout_flag  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (start) begin
            gold_inside_q <= gold_in;
            gold_area_q   <= gold_area;
            out_q         <= rd_point;
            send_cnt      <= IDX_W'(1);
          end
        end
        ST_SEND: begin
          if (send_cnt == SEND_END) begin
            out_q    <= '0;
            send_cnt <= '0;
            wait_cnt <= '0;
          end else begin
            out_q    <= rd_point;
            send_cnt <= send_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_hit) begin
            if (~&fail_cnt) fail_cnt <= fail_cnt + 1'b1;
            last_pass    <= 1'b0;
            timeout_flag <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (gf_valid) begin
              cap_inside <= gf_inside;
              cap_area   <= gf_area;
            end
          end
        end
        ST_CHECK: begin
          last_pass <= result_pass;
          if (result_pass) begin
            if (~&pass_cnt) pass_cnt <= pass_cnt + 1'b1;
          end else begin
            if (~&fail_cnt) fail_cnt <= fail_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign X = out_q.x;
  assign Y = out_q.y;
  assign R = out_q.r;

endmodule

// File: tb/tb_geofence_driver.sv
// Self-checking bench for geofence_driver: a transaction-level model tracks the
// anchor buffer, expected stream, verdicts, counters and sticky timeout flag.
module tb_geofence_driver;

  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [9:0]  wr_x, wr_y;
  logic [10:0] wr_r;
  logic        gold_in;
  logic [21:0] gold_area;
  logic        start;
  logic [9:0]  X, Y;
  logic [10:0] R;
  logic        gf_valid;
  logic        gf_inside;
  logic [21:0] gf_area;
  logic        busy, done, last_pass, timeout_flag;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;

  geofence_driver #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_r         (wr_r),
    .gold_in      (gold_in),
    .gold_area    (gold_area),
    .start        (start),
    .X            (X),
    .Y            (Y),
    .R            (R),
    .gf_valid     (gf_valid),
    .gf_inside    (gf_inside),
    .gf_area      (gf_area),
    .busy         (busy),
    .done         (done),
    .last_pass    (last_pass),
    .timeout_flag (timeout_flag),
    .pass_cnt     (pass_cnt),
    .fail_cnt     (fail_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [9:0]  m_x [6];
  logic [9:0]  m_y [6];
  logic [10:0] m_r [6];
  int          exp_pass, exp_fail;
  bit          exp_last, exp_flag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_x[i] = '0; m_y[i] = '0; m_r[i] = '0;
    end
    exp_pass = 0; exp_fail = 0; exp_last = 1'b0; exp_flag = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_pass_cnt"}, 32'(pass_cnt), exp_pass);
    check({tag, "_fail_cnt"}, 32'(fail_cnt), exp_fail);
    check({tag, "_last_pass"}, 32'(last_pass), 32'(exp_last));
    check({tag, "_timeout_flag"}, 32'(timeout_flag), 32'(exp_flag));
  endtask

  task automatic write_point(input int idx, input logic [9:0] x, input logic [9:0] y,
                             input logic [10:0] r);
    wr_en = 1'b1; wr_idx = 3'(idx); wr_x = x; wr_y = y; wr_r = r;
    tick();
    wr_en = 1'b0;
    if (idx < 6) begin
      m_x[idx] = x; m_y[idx] = y; m_r[idx] = r;
    end
  endtask

  // One full object transaction; poke injects start/wr_en/gf_valid mid-SEND.
  task automatic run_txn(input bit gold, input logic [21:0] garea, input bit respond,
                         input int delay, input bit r_in, input logic [21:0] r_area,
                         input bit poke);
    int  k;
    bit  seen;
    int  exp_k;
    bit  ok;
    gold_in = gold; gold_area = garea; start = 1'b1;
    tick();
    start = 1'b0; gold_in = ~gold; gold_area = ~garea;
    for (int i = 0; i < 6; i++) begin
      check("send_busy", 32'(busy), 1);
      check("send_x", 32'(X), 32'(m_x[i]));
      check("send_y", 32'(Y), 32'(m_y[i]));
      check("send_r", 32'(R), 32'(m_r[i]));
      if (poke && i == 2) begin
        start = 1'b1; wr_en = 1'b1; wr_idx = 3'd0;
        wr_x = 10'($urandom); wr_y = 10'($urandom); wr_r = 11'($urandom);
        gf_valid = 1'b1; gf_inside = r_in; gf_area = r_area;
      end
      tick();
      start = 1'b0; wr_en = 1'b0; gf_valid = 1'b0;
    end
    check("wait_x_zero", 32'({X, Y, R}), 0);
    seen = 1'b0;
    k = 0;
    while (!seen && k < TIMEOUT + 20) begin
      k++;
      if (done) begin
        seen = 1'b1;
      end else begin
        gf_valid  = respond && (k == delay);
        gf_inside = r_in;
        gf_area   = r_area;
        tick();
        gf_valid = 1'b0;
      end
    end
    exp_k = respond ? delay + 1 : TIMEOUT + 1;
    if (seen) begin
      check("done_cycle", k, exp_k);
      check("done_busy", 32'(busy), 1);
    end else begin
      check("done_seen", 0, 1);
    end
    ok = respond && (r_in == gold) && (r_area == garea);
    if (ok) begin
      if (exp_pass < MAXC) exp_pass++;
    end else begin
      if (exp_fail < MAXC) exp_fail++;
    end
    exp_last = ok;
    if (!respond) exp_flag = 1'b1;
    tick();
    check("post_done", 32'(done), 0);
    check("post_busy", 32'(busy), 0);
    check_stats("post");
  endtask

  initial begin
    bit          g;
    logic [21:0] a;
    int          kind;
    logic [21:0] ra;
    bit          ri;

    reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_r = '0;
    gold_in = 1'b0; gold_area = '0; start = 1'b0;
    gf_valid = 1'b0; gf_inside = 1'b0; gf_area = '0;
    model_reset();
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_xyr", 32'({X, Y, R}), 0);
    check_stats("rst");
    reset = 1'b0;
    tick();

    // Anchor load, including the ignored slots 6 and 7
    for (int i = 0; i < 6; i++)
      write_point(i, 10'($urandom), 10'($urandom), 11'($urandom));
    write_point(6, 10'h3FF, 10'h3FF, 11'h7FF);
    write_point(7, 10'h155, 10'h2AA, 11'h555);

    run_txn(1'b1, 22'd1000, 1'b1, 10, 1'b1, 22'd1000, 1'b0);  // pass
    run_txn(1'b1, 22'd1000, 1'b1, 10, 1'b1, 22'd999,  1'b0);  // area mismatch
    run_txn(1'b0, 22'd5,    1'b0, 0,  1'b0, 22'd0,    1'b0);  // timeout
    run_txn(1'b1, 22'd1000, 1'b1, 3,  1'b1, 22'd1000, 1'b0);  // flag stays sticky
    run_txn(1'b1, 22'd77,   1'b1, 5,  1'b1, 22'd77,   1'b1);  // pokes during SEND
    run_txn(1'b0, 22'd123,  1'b1, 1,  1'b0, 22'd123,  1'b0);  // buffer must be unchanged

    // Randomised transactions with occasional reloads
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 2) == 0)
        write_point($urandom_range(0, 7), 10'($urandom), 10'($urandom), 11'($urandom));
      g    = 1'($urandom);
      a    = 22'($urandom);
      kind = $urandom_range(0, 3);
      ri   = (kind == 1) ? ~g : g;
      ra   = (kind == 2) ? (a ^ 22'h200000) : (kind == 3) ? (a ^ 22'h000001) : a;
      run_txn(g, a, ($urandom_range(0, 7) != 0), $urandom_range(1, 12), ri, ra, 1'b0);
    end

    // Reset on the third SEND cycle
    gold_in = 1'b1; gold_area = 22'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_send_busy", 32'(busy), 1);
    reset = 1'b1;
    tick();
    model_reset();
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_xyr", 32'({X, Y, R}), 0);
    check_stats("abort");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_idle_done", 32'(done), 0);
    end
    run_txn(1'b1, 22'd1000, 1'b1, 4, 1'b1, 22'd1000, 1'b0);  // buffer cleared -> zero stream

    // Saturation of pass_cnt, using the full-width area
    write_point(2, 10'd17, 10'd900, 11'd2000);
    for (int n = 0; n < MAXC + 2; n++)
      run_txn(1'b1, 22'h3FFFFF, 1'b1, 1, 1'b1, 22'h3FFFFF, 1'b0);
    check("sat_pass_cnt", 32'(pass_cnt), MAXC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
